memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the single-port 256x32 shared memory.
- It accepts read/write requests from NUM_REQ client modules and grants the memory to one client at a time.
- It drives the memory's address, read/write flag (1=read, 0=write), write data and enable.
- It returns read data and a one-cycle acknowledge to the winning client.

Parameters:
- NUM_REQ, 4, number of client ports (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory word width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-client request level
- req_rw  input  NUM_REQ  per-client op: 1=read, 0=write
- req_addr  input  NUM_REQ*ADDR_W  flattened addresses; client i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  flattened write data, same packing
- grant  output  NUM_REQ  one-hot, high from ISSUE through ACK for the serviced client
- ack  output  NUM_REQ  one-hot single-cycle completion pulse
- rdata  output  DATA_W  read data, valid while ack is high for a read
- mem_addr  output  ADDR_W  to memory address
- mem_rw  output  1  to memory readWrite
- mem_wdata  output  DATA_W  to memory dataIn
- mem_en  output  1  to memory enabled
- mem_rdata  input  DATA_W  from memory dataOut

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - grant, ack, mem_en, mem_rw, mem_addr, mem_wdata and rdata all 0.
  - Round-robin pointer last=NUM_REQ-1, so client 0 has first priority after reset.
- Reset asserted mid-operation aborts the transaction: no ack is issued, and a write already enabled may or may not have completed in memory.
- FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the winner w as the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Latch req_addr[w], req_rw[w] and req_wdata[w] into mem_addr, mem_rw and mem_wdata.
  - Set grant=1<<w and mem_en=1, then go to ISSUE.
- ISSUE: mem_en=1 for exactly this one cycle; the memory samples at the end of the cycle. Go to WAIT.
- WAIT:
  - mem_en=0.
  - mem_rdata is valid this cycle for reads: if mem_rw=1, capture rdata<=mem_rdata.
  - For writes, rdata keeps its previous value.
  - Go to ACK.
- ACK:
  - ack=1<<w for one cycle; rdata is stable.
  - last<=w.
  - grant clears on exit. Go to IDLE.
- Latency: req sampled high in IDLE at cycle N -> mem_en high in cycle N+1 -> ack high in cycle N+3. One operation per 4 cycles, with identical latency for reads and writes.
- Clients must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request, but round-robin order serves other pending clients first.
- Request inputs are latched at grant. Later changes to addr/rw/wdata, or dropping req, do not affect the in-flight operation, and ack is still pulsed.
- Simultaneous requests: exactly one winner per arbitration; the losers wait with req held.
- Starvation bound: a held request is served within NUM_REQ transactions.
- mem_en is never high for more than one consecutive cycle. grant and ack are always zero or one-hot.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: the winner is always the lowest-index set bit of req; `last` is unused. Client 0 can starve the others.
- Undefined: round-robin as above.
- All timing is identical in both builds.

Test Plan:
- Reset, then req=4'b0001, rw=0, addr=8'h10, wdata=32'hDEADBEEF -> mem_en high exactly one cycle with mem_addr=8'h10, mem_rw=0; ack=4'b0001 three cycles after the req sample; memory[0x10]=32'hDEADBEEF.
- Client 2 reads addr 8'h10 after that write -> ack=4'b0100 with rdata=32'hDEADBEEF at N+3; write-ack cycles leave rdata unchanged.
- req=4'b1111 held, each client dropping its req after its ack -> grant sequence 0,1,2,3; with ARB_FIXED_PRIORITY_EN and requests reasserted the sequence is 0,0,0...
- Client 1 changes req_addr from 8'h20 to 8'h30 and drops req while in ISSUE -> memory is accessed at 8'h20 and ack[1] still pulses.
- rst_n pulled low during WAIT -> all outputs 0 immediately (asynchronously); no ack; next request from client 0 is served normally.
- Random 1000 ops from 4 clients against a reference memory model -> all read data matches; mem_en never high two consecutive cycles; grant/ack always one-hot or zero.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter in front of a single-port 256x32 memory.
// Each transaction takes four cycles: IDLE (arbitrate) -> ISSUE (mem_en) ->
// WAIT (capture read data) -> ACK (one-cycle ack pulse). All outputs are registered.
// Optional build macro ARB_FIXED_PRIORITY_EN: when defined, the lowest-index
// requester always wins and the round-robin pointer is removed.
module memory_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rw,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_en,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_rw;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_en;

    logic [NUM_REQ-1:0]  w_grant_next;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic [DATA_W-1:0]   w_rdata_next;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic                w_mem_rw_next;
    logic [DATA_W-1:0]   w_mem_wdata_next;
    logic                w_mem_en_next;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_rw;
    logic [DATA_W-1:0]   w_sel_wdata;

`ifndef ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    r_winner;
`endif

    // Pick the winning client and mux out its request fields.
    always_comb begin
        w_found     = |req;
        w_winner    = '0;
        w_sel_addr  = '0;
        w_sel_rw    = 1'b0;
        w_sel_wdata = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner = IDX_W'(i);
            end
        end
`else
        // Scan downwards so the closest requester after r_last is assigned last and wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[IDX_W'((int'(r_last) + k) % NUM_REQ)]) begin
                w_winner = IDX_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_rw    = req_rw[i];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic for the four-phase transaction FSM.
    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_ack_next       = '0;
        w_rdata_next     = r_rdata;
        w_mem_addr_next  = r_mem_addr;
        w_mem_rw_next    = r_mem_rw;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_en_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_next     = NUM_REQ'(1) << w_winner;
                    w_mem_addr_next  = w_sel_addr;
                    w_mem_rw_next    = w_sel_rw;
                    w_mem_wdata_next = w_sel_wdata;
                    w_mem_en_next    = 1'b1;
                    w_state_next     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_mem_rw) begin
                    w_rdata_next = mem_rdata;
                end
                w_ack_next   = r_grant;
                w_state_next = S_ACK;
            end
            S_ACK: begin
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_en    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_ack       <= w_ack_next;
            r_rdata     <= w_rdata_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_rw    <= w_mem_rw_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_en    <= w_mem_en_next;
        end
    end

`ifndef ARB_FIXED_PRIORITY_EN
    // Round-robin pointer: remember the winner at grant, commit it as 'last' at ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_winner <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_winner <= w_winner;
            end
            if (r_state == S_ACK) begin
                r_last <= r_winner;
            end
        end
    end
`endif

    assign grant     = r_grant;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_rw    = r_mem_rw;
    assign mem_wdata = r_mem_wdata;
    assign mem_en    = r_mem_en;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: drives the arbiter with directed and random client traffic,
// hosts a behavioural 256x32 memory, and compares every cycle against a
// transaction-level reference model (arbitration order, latency, data).
module tb_memory_arbiter;

   localparam int NR = 4;
   localparam int AW = 8;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR-1:0]     req_rw = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     ack;
   logic [DW-1:0]     rdata;
   logic [AW-1:0]     mem_addr;
   logic              mem_rw;
   logic [DW-1:0]     mem_wdata;
   logic              mem_en;
   logic [DW-1:0]     mem_rdata = '0;

   memory_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .ack(ack),
      .rdata(rdata), .mem_addr(mem_addr), .mem_rw(mem_rw),
      .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_rdata(mem_rdata)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Behavioural single-port synchronous memory: read data appears the cycle after enable.
   logic [DW-1:0] memArray [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_rw) mem_rdata <= memArray[mem_addr];
         else        memArray[mem_addr] <= mem_wdata;
      end
   end

   // Scoreboard counters.
   int checks = 0;
   int errors = 0;

   // Client intent.
   bit            cliPending [NR];
   logic          cliRw      [NR];
   logic [AW-1:0] cliAddr    [NR];
   logic [DW-1:0] cliWdata   [NR];

   // Reference model: one transaction in flight, fixed latencies from the sample cycle.
   int            cyc = 0;
   int            freeCycle = 0;
   int            enCycle = -10;
   int            ackCycle = -10;
   int            expW = 0;
   logic          expRw = 1'b0;
   logic [AW-1:0] expAddr = '0;
   logic [DW-1:0] expWdata = '0;
   logic [DW-1:0] expReadVal = '0;
   logic [DW-1:0] refRdata = '0;
   logic [DW-1:0] refMem  [256];
   bit            written [256];
   int            refLast = NR - 1;
   int            opsDone = 0;
   int            ackOrder [$];
   logic [DW-1:0] lastAckRdata = '0;
   bit            scramble = 1'b0;
   bit            abortInWait = 1'b0;

   // Count one comparison and report it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // One clock cycle: check outputs against the model, update clients, drive, arbitrate.
   task automatic applyStimulus(input bit randomMode);
      logic [NR-1:0] expGrant;
      @(negedge clk);
      cyc++;
      if (cyc == ackCycle && expRw) refRdata = expReadVal;
      expGrant = (cyc >= enCycle && cyc <= ackCycle) ? (NR'(1) << expW) : '0;
      checkOutput("grant", grant, expGrant);
      checkOutput("ack", ack, (cyc == ackCycle) ? (NR'(1) << expW) : NR'(0));
      checkOutput("mem_en", mem_en, (cyc == enCycle) ? 1 : 0);
      checkOutput("rdata", rdata, refRdata);
      if (cyc == enCycle) begin
         checkOutput("mem_addr", mem_addr, expAddr);
         checkOutput("mem_rw", mem_rw, expRw);
         if (!expRw) checkOutput("mem_wdata", mem_wdata, expWdata);
      end
      for (int i = 0; i < NR; i++) if (ack[i]) ackOrder.push_back(i);
      if (ack != '0) lastAckRdata = rdata;
      if (cyc == ackCycle) begin
         cliPending[expW] = 1'b0;
         opsDone++;
      end
      if (scramble && cyc == enCycle && expW == 1) begin
         cliAddr[1]    = 8'h30;
         cliRw[1]      = ~cliRw[1];
         cliPending[1] = 1'b0;
         scramble      = 1'b0;
      end
      if (abortInWait && enCycle > 0 && cyc == enCycle + 1) begin
         rst_n = 1'b0;
         #1;
         checkOutput("rstGrant", grant, 0);
         checkOutput("rstAck", ack, 0);
         checkOutput("rstMemAddr", mem_addr, 0);
         checkOutput("rstMemRw", mem_rw, 0);
         checkOutput("rstRdata", rdata, 0);
         #1;
         rst_n = 1'b1;
         abortInWait = 1'b0;
         enCycle  = -10;
         ackCycle = -10;
         refLast  = NR - 1;
         refRdata = '0;
         freeCycle = cyc;
         for (int i = 0; i < NR; i++) cliPending[i] = 1'b0;
      end
      if (randomMode) begin
         for (int i = 0; i < NR; i++) begin
            if (!cliPending[i] && !(cyc == ackCycle && expW == i) && $urandom_range(0, 2) == 0) begin
               cliPending[i] = 1'b1;
               cliAddr[i]    = AW'($urandom_range(0, 15));
               cliRw[i]      = written[cliAddr[i]] ? 1'($urandom_range(0, 1)) : 1'b0;
               cliWdata[i]   = $urandom;
            end
         end
      end
      for (int i = 0; i < NR; i++) begin
         req[i]                 = cliPending[i];
         req_rw[i]              = cliRw[i];
         req_addr[i*AW +: AW]   = cliAddr[i];
         req_wdata[i*DW +: DW]  = cliWdata[i];
      end
      if (cyc >= freeCycle && req != '0) begin
`ifdef ARB_FIXED_PRIORITY_EN
         for (int k = NR - 1; k >= 0; k--) if (req[k]) expW = k;
`else
         for (int k = NR; k >= 1; k--) if (req[(refLast + k) % NR]) expW = (refLast + k) % NR;
`endif
         refLast   = expW;
         enCycle   = cyc + 1;
         ackCycle  = cyc + 3;
         freeCycle = cyc + 4;
         expRw     = cliRw[expW];
         expAddr   = cliAddr[expW];
         expWdata  = cliWdata[expW];
         if (expRw) expReadVal = refMem[expAddr];
         else begin
            refMem[expAddr]  = expWdata;
            written[expAddr] = 1'b1;
         end
      end
   endtask

   // Set up one client's request intent.
   task automatic setClient(input int c, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cliPending[c] = 1'b1;
      cliRw[c]      = rw;
      cliAddr[c]    = a;
      cliWdata[c]   = d;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0);
   endtask

   // Hard time limit so the run always terminates.
   initial begin
      #5ms;
      $display("[TB] FAIL timeout reached before completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int orderBase;
      for (int i = 0; i < 256; i++) begin
         memArray[i] = '0;
         refMem[i]   = '0;
         written[i]  = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
         cliPending[i] = 1'b0;
         cliRw[i]      = 1'b0;
         cliAddr[i]    = '0;
         cliWdata[i]   = '0;
      end

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("resetGrant", grant, 0);
      checkOutput("resetAck", ack, 0);
      checkOutput("resetMemEn", mem_en, 0);
      checkOutput("resetMemAddr", mem_addr, 0);
      checkOutput("resetRdata", rdata, 0);
      #1 rst_n = 1'b1;

      // Client 0 write, then client 2 reads it back, then a write leaves rdata alone.
      $display("[TB] directed write/read");
      setClient(0, 1'b0, 8'h10, 32'hDEADBEEF);
      runCycles(6);
      checkOutput("memWrite10", memArray[8'h10], 32'hDEADBEEF);
      setClient(2, 1'b1, 8'h10, 32'h0);
      runCycles(6);
      checkOutput("readBack10", lastAckRdata, 32'hDEADBEEF);
      setClient(3, 1'b0, 8'h11, 32'hCAFEF00D);
      runCycles(6);
      checkOutput("rdataAfterWrite", rdata, 32'hDEADBEEF);

      // All four request together: round-robin serves 0,1,2,3.
      $display("[TB] simultaneous requests");
      orderBase = ackOrder.size();
      for (int i = 0; i < NR; i++) setClient(i, 1'b0, AW'(8'h40 + i), DW'(32'h1000 + i));
      runCycles(20);
      checkOutput("orderCount", ackOrder.size() - orderBase, NR);
      for (int i = 0; i < NR; i++)
         if (ackOrder.size() > orderBase + i) checkOutput("grantOrder", ackOrder[orderBase + i], i);

      // Client 1 changes address and drops req during ISSUE: latched op still completes.
      $display("[TB] late input change");
      setClient(1, 1'b0, 8'h20, 32'h12345678);
      scramble = 1'b1;
      runCycles(6);
      checkOutput("lateAck1", ackOrder[$], 1);
      checkOutput("memWrite20", memArray[8'h20], 32'h12345678);
      setClient(0, 1'b1, 8'h20, 32'h0);
      runCycles(6);
      checkOutput("readBack20", lastAckRdata, 32'h12345678);

      // Reset during WAIT aborts the read with no ack; client 0 is then served normally.
      $display("[TB] reset abort");
      orderBase = ackOrder.size();
      setClient(2, 1'b1, 8'h10, 32'h0);
      abortInWait = 1'b1;
      runCycles(8);
      checkOutput("abortNoAck", ackOrder.size() - orderBase, 0);
      setClient(0, 1'b0, 8'h50, 32'h55AA55AA);
      runCycles(6);
      checkOutput("postResetAck", ackOrder.size() - orderBase, 1);
      if (ackOrder.size() > orderBase) checkOutput("postResetClient", ackOrder[$], 0);
      checkOutput("memWrite50", memArray[8'h50], 32'h55AA55AA);

      // Random traffic from all clients.
      $display("[TB] random traffic");
      opsDone = 0;
      for (int n = 0; n < 20000 && opsDone < 1000; n++) applyStimulus(1'b1);
      for (int i = 0; i < NR; i++) cliPending[i] = 1'b0;
      runCycles(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
